// File: rtl/cordic_scheduler_if.sv
// Request/response bundle between requesters, the CORDIC scheduler and the result consumer.
// The scheduler takes the slave view; the requester/consumer side takes the master view.
interface cordic_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [32*NUM_REQ-1:0] req_theta;
    logic [NUM_REQ-1:0]    req_ready;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [ID_W-1:0]       resp_id;
    logic [31:0]           resp_cos;
    logic [31:0]           resp_sin;

    modport master (
        output req_valid, req_theta, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_cos, resp_sin
    );

    modport slave (
        input  req_valid, req_theta, resp_ready,
        output req_ready, resp_valid, resp_id, resp_cos, resp_sin
    );
endinterface

// File: rtl/cordic_scheduler.sv
// Round-robin front end for a shared, fixed-latency pipelined CORDIC rotator.
// Tags ride alongside the rotator; results land in a credit-protected output FIFO.
module cordic_scheduler #(
    parameter int          NUM_REQ    = 4,
    parameter int          ID_W       = 2,
    parameter int          PIPE_LAT   = 30,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] K_GAIN     = 32'h3F1B74EE
) (
    input  logic                 clk,
    input  logic                 rst,
    cordic_scheduler_if.slave    bus,
    output logic [31:0]          cordic_x_start,
    output logic [31:0]          cordic_y_start,
    output logic [31:0]          cordic_theta,
    input  logic [31:0]          cordic_x_cos,
    input  logic [31:0]          cordic_y_sin,
    output logic                 busy
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int ENT_W = ID_W + 64;

    logic [31:0]          theta_arr [NUM_REQ];
    logic [ID_W-1:0]      last_grant_reg;
    logic [ID_W-1:0]      grant_id;
    logic                 grant_any;
    logic                 credit_ok;
    logic                 accept;
    logic [CNT_W-1:0]     inflight_reg, inflight_next;
    logic [CNT_W-1:0]     fifo_cnt_reg, fifo_cnt_next;
    logic [CNT_W:0]       outstanding;

    logic [31:0]          theta_reg;
    logic                 issue_vld_reg;
    logic [ID_W-1:0]      issue_id_reg;
    logic [PIPE_LAT-1:0]      tag_vld_reg;
    logic [PIPE_LAT*ID_W-1:0] tag_id_reg;
    logic                 retire;
    logic [ID_W-1:0]      retire_id;

    logic [ENT_W-1:0]     fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_reg, rd_ptr_reg;
    logic [ENT_W-1:0]     head;
    logic                 fifo_empty;
    logic                 pop;
    logic                 busy_reg;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign theta_arr[gi]     = bus.req_theta[32*gi +: 32];
            assign bus.req_ready[gi] = accept && (grant_id == ID_W'(gi));
        end
    endgenerate

    // Credit covers both in-flight rotations and buffered results, so retire never overflows the FIFO.
    assign outstanding = {1'b0, inflight_reg} + {1'b0, fifo_cnt_reg};
    assign credit_ok   = outstanding < (CNT_W+1)'(FIFO_DEPTH);
    assign accept      = grant_any && credit_ok && !rst;

    // Scan from the farthest offset back to the nearest so the nearest valid requester wins.
    always_comb begin
        int idx;
        idx       = 0;
        grant_any = 1'b0;
        grant_id  = '0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            idx = (int'(last_grant_reg) + off) % NUM_REQ;
            if (bus.req_valid[idx]) begin
                grant_any = 1'b1;
                grant_id  = ID_W'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            theta_reg      <= 32'h0;
            issue_vld_reg  <= 1'b0;
            issue_id_reg   <= '0;
            last_grant_reg <= ID_W'(NUM_REQ - 1);
        end else begin
            issue_vld_reg <= accept;
            issue_id_reg  <= grant_id;
            theta_reg     <= accept ? theta_arr[grant_id] : 32'h0;
            if (accept)
                last_grant_reg <= grant_id;
        end
    end

    assign cordic_theta   = theta_reg;
    assign cordic_x_start = K_GAIN;
    assign cordic_y_start = 32'h0;

    // The issue register is the rotator's input stage; the tag line covers the remaining latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_vld_reg <= '0;
            tag_id_reg  <= '0;
        end else begin
            tag_vld_reg <= {tag_vld_reg[PIPE_LAT-2:0], issue_vld_reg};
            tag_id_reg  <= {tag_id_reg[(PIPE_LAT-1)*ID_W-1:0], issue_id_reg};
        end
    end

    assign retire    = tag_vld_reg[PIPE_LAT-1];
    assign retire_id = tag_id_reg[PIPE_LAT*ID_W-1 -: ID_W];

    always_ff @(posedge clk) begin
        if (retire)
            fifo_mem[wr_ptr_reg] <= {retire_id, cordic_x_cos, cordic_y_sin};
    end

    assign fifo_empty     = (fifo_cnt_reg == '0);
    assign head           = fifo_mem[rd_ptr_reg];
    assign bus.resp_valid = !fifo_empty;
    assign bus.resp_id    = fifo_empty ? '0    : head[ENT_W-1 -: ID_W];
    assign bus.resp_cos   = fifo_empty ? 32'h0 : head[63:32];
    assign bus.resp_sin   = fifo_empty ? 32'h0 : head[31:0];
    assign pop            = bus.resp_valid && bus.resp_ready;

    always_comb begin
        inflight_next = inflight_reg;
        case ({accept, retire})
            2'b10:   inflight_next = inflight_reg + CNT_W'(1);
            2'b01:   inflight_next = inflight_reg - CNT_W'(1);
            default: inflight_next = inflight_reg;
        endcase
        fifo_cnt_next = fifo_cnt_reg;
        case ({retire, pop})
            2'b10:   fifo_cnt_next = fifo_cnt_reg + CNT_W'(1);
            2'b01:   fifo_cnt_next = fifo_cnt_reg - CNT_W'(1);
            default: fifo_cnt_next = fifo_cnt_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_reg <= '0;
            fifo_cnt_reg <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            busy_reg     <= 1'b0;
        end else begin
            inflight_reg <= inflight_next;
            fifo_cnt_reg <= fifo_cnt_next;
            if (retire)
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            busy_reg <= (inflight_next != '0) || (fifo_cnt_next != '0);
        end
    end

    assign busy = busy_reg;
endmodule

// File: tb/tb_cordic_scheduler.sv
// Self-checking bench for cordic_scheduler: a table-driven rotator model plus an in-order scoreboard.
// All DUT sampling happens on the falling edge; stimulus changes 1 ns after the rising edge.
module tb_cordic_scheduler;
    localparam int          NUM_REQ    = 4;
    localparam int          ID_W       = 2;
    localparam int          PIPE_LAT   = 30;
    localparam int          FIFO_DEPTH = 8;
    localparam logic [31:0] K_GAIN     = 32'h3F1B74EE;
    localparam logic [31:0] PI6        = 32'h3F060A92;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [31:0]     theta;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [31:0] cordic_x_start, cordic_y_start, cordic_theta;
    logic [31:0] cordic_x_cos, cordic_y_sin;
    logic        busy;

    cordic_scheduler_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

    cordic_scheduler #(
        .NUM_REQ(NUM_REQ), .ID_W(ID_W), .PIPE_LAT(PIPE_LAT),
        .FIFO_DEPTH(FIFO_DEPTH), .K_GAIN(K_GAIN)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .cordic_x_start(cordic_x_start),
        .cordic_y_start(cordic_y_start),
        .cordic_theta(cordic_theta),
        .cordic_x_cos(cordic_x_cos),
        .cordic_y_sin(cordic_y_sin),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference results for the angles the bench uses; other angles map to distinct patterns.
    function automatic logic [31:0] model_cos(input logic [31:0] th);
        if (th == 32'h0)     return 32'h3F800000;
        else if (th == PI6)  return 32'h3F5DB3D7;
        else                 return th ^ 32'h5A5A1234;
    endfunction

    function automatic logic [31:0] model_sin(input logic [31:0] th);
        if (th == 32'h0)     return 32'h0;
        else if (th == PI6)  return 32'h3F000000;
        else                 return {th[15:0], th[31:16]} + 32'd7;
    endfunction

    logic [31:0] rot_pipe [PIPE_LAT];
    always @(posedge clk) begin
        rot_pipe[0] <= cordic_theta;
        for (int i = 1; i < PIPE_LAT; i++)
            rot_pipe[i] <= rot_pipe[i-1];
    end
    assign cordic_x_cos = model_cos(rot_pipe[PIPE_LAT-1]);
    assign cordic_y_sin = model_sin(rot_pipe[PIPE_LAT-1]);

    exp_t exp_q[$];
    int   grant_q[$];
    int   n_checks   = 0;
    int   n_fail     = 0;
    int   accept_cnt = 0;
    int   resp_cnt   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic monitor();
        exp_t e;
        if (rst) begin
            exp_q.delete();
            return;
        end
        if (bus.resp_valid) begin
            if (exp_q.size() == 0) begin
                chk("spurious_resp", 64'd1, 64'd0);
            end else begin
                e = exp_q[0];
                chk("resp_id", 64'(bus.resp_id), 64'(e.id));
                chk("resp_cos", 64'(bus.resp_cos), 64'(model_cos(e.theta)));
                chk("resp_sin", 64'(bus.resp_sin), 64'(model_sin(e.theta)));
                if (bus.resp_ready) begin
                    void'(exp_q.pop_front());
                    resp_cnt++;
                    $display("resp id=%0d cos=%h sin=%h", bus.resp_id, bus.resp_cos, bus.resp_sin);
                end
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (bus.req_valid[i] && bus.req_ready[i]) begin
                e.id    = ID_W'(i);
                e.theta = bus.req_theta[32*i +: 32];
                exp_q.push_back(e);
                grant_q.push_back(i);
                accept_cnt++;
                $display("req  id=%0d theta=%h", i, e.theta);
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic drain(input string tag);
        int k;
        k = 0;
        while ((busy || exp_q.size() != 0) && k < 300) begin
            step();
            k++;
        end
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_pending"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got time %0t expected end", $time);
        $fatal(1);
    end

    initial begin
        int n, a0, cnt, k;
        rst            = 1'b1;
        bus.req_valid  = '1;
        bus.req_theta  = '0;
        bus.resp_ready = 1'b1;

        // Reset state, including grant suppression while rst is high.
        idle(3);
        chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
        chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        chk("rst_resp_id", 64'(bus.resp_id), 64'd0);
        chk("rst_resp_cos", 64'(bus.resp_cos), 64'd0);
        chk("rst_resp_sin", 64'(bus.resp_sin), 64'd0);
        chk("rst_theta", 64'(cordic_theta), 64'd0);
        chk("rst_x_start", 64'(cordic_x_start), 64'(K_GAIN));
        chk("rst_y_start", 64'(cordic_y_start), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        bus.req_valid = '0;
        rst = 1'b0;
        step();

        // Single request from requester 2 with theta = 0.
        bus.req_valid = 4'b0100;
        bus.req_theta[32*2 +: 32] = 32'h0;
        #1;
        chk("t1_ready", 64'(bus.req_ready), 64'b0100);
        step();
        bus.req_valid = '0;
        n = 1;
        while (!bus.resp_valid && n < 100) begin
            step();
            n++;
        end
        chk("t1_latency", 64'(n), 64'(PIPE_LAT + 2));
        chk("t1_id", 64'(bus.resp_id), 64'd2);
        chk("t1_cos", 64'(bus.resp_cos), 64'h3F800000);
        chk("t1_sin", 64'(bus.resp_sin), 64'h0);
        chk("t1_busy", 64'(busy), 64'd1);
        drain("t1_drain");
        chk("t1_resp_cnt", 64'(resp_cnt), 64'd1);

        // Round-robin with all requesters continuously valid at pi/6.
        grant_q.delete();
        a0 = accept_cnt;
        bus.req_valid = '1;
        for (int i = 0; i < NUM_REQ; i++)
            bus.req_theta[32*i +: 32] = PI6;
        idle(FIFO_DEPTH);
        chk("rr_burst", 64'(accept_cnt - a0), 64'(FIFO_DEPTH));
        idle(60);
        bus.req_valid = '0;
        drain("rr_drain");
        for (int i = 0; i < grant_q.size(); i++)
            chk("rr_order", 64'(grant_q[i]), 64'((3 + i) % NUM_REQ));

        // Backpressure: requester 1 streams while the consumer stalls.
        bus.resp_ready = 1'b0;
        a0 = accept_cnt;
        bus.req_valid = 4'b0010;
        for (int i = 0; i < 50; i++) begin
            bus.req_theta[32*1 +: 32] = 32'h3E000000 + 32'(accept_cnt * 256);
            step();
        end
        chk("bp_accepts", 64'(accept_cnt - a0), 64'(FIFO_DEPTH));
        chk("bp_ready_low", 64'(bus.req_ready), 64'd0);
        bus.resp_ready = 1'b1;
        step();
        bus.resp_ready = 1'b0;
        bus.req_theta[32*1 +: 32] = 32'h3E000000 + 32'(accept_cnt * 256);
        chk("bp_credit_back", 64'(bus.req_ready), 64'b0010);
        for (int i = 0; i < 40; i++) begin
            bus.req_theta[32*1 +: 32] = 32'h3E000000 + 32'(accept_cnt * 256);
            step();
        end
        chk("bp_one_more", 64'(accept_cnt - a0), 64'(FIFO_DEPTH + 1));
        bus.req_valid = '0;
        bus.resp_ready = 1'b1;
        drain("bp_drain");

        // Boundary: seven outstanding, then a pop and a new request in the same cycle.
        bus.resp_ready = 1'b0;
        a0 = accept_cnt;
        bus.req_valid = 4'b0001;
        k = 0;
        while (accept_cnt - a0 < 7 && k < 50) begin
            bus.req_theta[31:0] = 32'h3C000000 + 32'(accept_cnt * 512);
            step();
            k++;
        end
        bus.req_valid = '0;
        idle(40);
        bus.req_valid = 4'b0001;
        bus.req_theta[31:0] = 32'h3C000000 + 32'(accept_cnt * 512);
        bus.resp_ready = 1'b1;
        #1;
        chk("bd_ready", 64'(bus.req_ready), 64'b0001);
        step();
        bus.resp_ready = 1'b0;
        for (int i = 0; i < 30; i++) begin
            bus.req_theta[31:0] = 32'h3C000000 + 32'(accept_cnt * 512);
            step();
        end
        chk("bd_accepts", 64'(accept_cnt - a0), 64'd9);
        chk("bd_full", 64'(bus.req_ready), 64'd0);
        bus.req_valid = '0;
        bus.resp_ready = 1'b1;
        drain("bd_drain");

        // Reset while five requests are in flight.
        a0 = accept_cnt;
        bus.req_valid = 4'b1000;
        k = 0;
        while (accept_cnt - a0 < 5 && k < 50) begin
            bus.req_theta[32*3 +: 32] = 32'h3D800000 + 32'(accept_cnt * 128);
            step();
            k++;
        end
        bus.req_valid = '0;
        idle(5);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mr_busy", 64'(busy), 64'd0);
        cnt = 0;
        repeat (PIPE_LAT + 5) begin
            step();
            if (bus.resp_valid) cnt++;
        end
        chk("mr_no_resp", 64'(cnt), 64'd0);
        bus.req_valid = 4'b0001;
        bus.req_theta[31:0] = 32'h3E800000;
        #1;
        chk("mr_grant0", 64'(bus.req_ready), 64'b0001);
        step();
        bus.req_valid = '0;
        n = 0;
        while (!bus.resp_valid && n < 100) begin
            step();
            n++;
        end
        chk("mr_resp", 64'(bus.resp_valid), 64'd1);
        drain("mr_drain");

        // Sparse traffic: requesters 0 and 3 alternate with idle cycles between.
        a0 = accept_cnt;
        for (int i = 0; i < 64; i++) begin
            case (i % 4)
                0: begin
                    bus.req_valid = 4'b0001;
                    bus.req_theta[31:0] = 32'h3D000000 + 32'(i * 64);
                end
                2: begin
                    bus.req_valid = 4'b1000;
                    bus.req_theta[32*3 +: 32] = 32'h3D100000 + 32'(i * 64);
                end
                default: bus.req_valid = '0;
            endcase
            step();
        end
        bus.req_valid = '0;
        drain("sp_drain");
        chk("sp_some", 64'(accept_cnt - a0 > 0), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
